// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types, constants and offset helper for the pipeline controller
package pipeline_ctrl_pkg;

    localparam int PRED_ALWAYS = 0;
    localparam int PRED_BTFN   = 1;

    localparam int RB_PC_W  = 16;
    localparam int RB_PSW_W = 16;

    typedef struct packed {
        logic [RB_PC_W-1:0]  pc;
        logic [RB_PSW_W-1:0] psw;
    } rb_entry_t;

    // Sign-extend an off_w-bit word offset to 32 bits and convert it to a byte offset
    function automatic logic [31:0] sext_shl1(input logic [31:0] off, input int off_w);
        logic [31:0] mask;
        logic        sign;
        logic [31:0] ext;
        mask = ~32'd0 << off_w;
        sign = |(off & (32'd1 << (off_w - 1)));
        ext  = sign ? (off | mask) : (off & ~mask);
        return {ext[30:0], 1'b0};
    endfunction

endpackage

// File: rtl/rollback_fifo.sv
// rtl/rollback_fifo.sv - small FIFO of alternate PC/PSW pairs with clear and head output
module rollback_fifo
    import pipeline_ctrl_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = rb_entry_t,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output entry_t           head,
    output logic             empty
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // a pop in the same cycle frees the slot the push needs
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    // storage, pointers and occupancy; clear squashes every entry at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW scoreboard with bubble insertion and static branch predictor with rollback
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int  NREG       = 8,
    parameter int  DEP_STAGES = 2,
    parameter int  PC_W       = 16,
    parameter int  PSW_W      = 16,
    parameter int  OFF_W      = 13,
    parameter int  RB_DEPTH   = 2,
    parameter int  PRED_MODE  = 0,
    localparam int CNT_W      = $clog2(RB_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [NREG-1:0]  dec_set,
    input  logic [NREG-1:0]  dec_dep,
    output logic [NREG-1:0]  stall,
    output logic             stall_any,
    input  logic             fet_valid,
    input  logic             fet_is_br,
    input  logic [OFF_W-1:0] fet_off,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [PSW_W-1:0] psw_in,
    output logic [PC_W-1:0]  pc_next,
    output logic             fetch_hold,
    input  logic             ex_resolve,
    input  logic             ex_mispred,
    output logic             flush,
    output logic [PC_W-1:0]  rb_pc,
    output logic [PSW_W-1:0] rb_psw,
    output logic [CNT_W-1:0] rb_count
);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [PSW_W-1:0] psw;
    } entry_t;

    logic [NREG-1:0] sb [DEP_STAGES];
    logic [NREG-1:0] sb_any;
    logic            rb_empty;
    entry_t          rb_head;
    entry_t          push_data;
    logic            mispredict;
    logic            resolve_ok;
    logic            fetch_go;
    logic            push;
    logic            pred_taken;
    logic [PC_W-1:0] ext;
    logic [PC_W-1:0] fall_pc;
    logic [PC_W-1:0] target_pc;

    // union of all in-flight pending writes
    always_comb begin
        sb_any = '0;
        for (int i = 0; i < DEP_STAGES; i++) begin
            sb_any = sb_any | sb[i];
        end
    end

    assign stall     = sb_any & dec_dep & {NREG{dec_valid}};
    assign stall_any = |stall;

    // a resolve against an empty queue is ignored entirely
    assign mispredict = ex_resolve & ex_mispred & ~rb_empty;
    assign resolve_ok = ex_resolve & ~ex_mispred & ~rb_empty;

    assign fetch_hold = fet_valid & fet_is_br & (rb_count == CNT_W'(RB_DEPTH)) & ~ex_resolve;

    assign ext       = PC_W'(sext_shl1(32'(fet_off), OFF_W));
    assign fall_pc   = pc_in + PC_W'(2);
    assign target_pc = fall_pc + ext;
    assign pred_taken = (PRED_MODE == PRED_BTFN) ? (fet_is_br & fet_off[OFF_W-1]) : fet_is_br;

    // fetch advances only when nothing higher priority owns this cycle
    assign fetch_go = fet_valid & ~stall_any & ~fetch_hold & ~flush & ~mispredict;
    assign push     = fetch_go & fet_is_br;

    assign push_data.pc  = pred_taken ? fall_pc : target_pc;
    assign push_data.psw = psw_in;

    rollback_fifo #(
        .DEPTH   (RB_DEPTH),
        .entry_t (entry_t)
    ) u_rb (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (resolve_ok),
        .clear     (mispredict),
        .count     (rb_count),
        .head      (rb_head),
        .empty     (rb_empty)
    );

    assign rb_pc  = rb_head.pc;
    assign rb_psw = rb_head.psw;

    // next fetch PC selection and the one-cycle flush pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_next <= '0;
            flush   <= 1'b0;
        end else begin
            flush <= mispredict;
            if (mispredict) begin
                pc_next <= rb_head.pc;
            end else if (fetch_go) begin
                pc_next <= pred_taken ? target_pc : fall_pc;
            end
        end
    end

    // scoreboard shift; a stalled or squashed decode slot enters as a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEP_STAGES; i++) begin
                sb[i] <= '0;
            end
        end else if (mispredict) begin
            for (int i = 0; i < DEP_STAGES; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= (dec_valid & ~stall_any & ~flush) ? dec_set : '0;
            for (int i = 1; i < DEP_STAGES; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    // resolving with nothing outstanding is an execute-side protocol error
    a_resolve_nonempty: assert property (@(posedge clk) disable iff (!rst_n) ex_resolve |-> !rb_empty);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - table-driven scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        dec_valid;
    logic [7:0]  dec_set;
    logic [7:0]  dec_dep;
    logic        fet_valid;
    logic        fet_is_br;
    logic [12:0] fet_off;
    logic [15:0] pc_in;
    logic [15:0] psw_in;
    logic        ex_resolve;
    logic        ex_mispred;

    logic [7:0]  stall,      b_stall;
    logic        stall_any,  b_stall_any;
    logic [15:0] pc_next,    b_pc_next;
    logic        fetch_hold, b_fetch_hold;
    logic        flush,      b_flush;
    logic [15:0] rb_pc,      b_rb_pc;
    logic [15:0] rb_psw,     b_rb_psw;
    logic [1:0]  rb_count,   b_rb_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        dv;
        logic [7:0]  set;
        logic [7:0]  dep;
        logic        fv;
        logic        fb;
        logic [12:0] off;
        logic [15:0] pc;
        logic [15:0] psw;
        logic        res;
        logic        mis;
        logic [7:0]  e_stall;
        logic        e_hold;
        logic [15:0] e_pc;
        logic        e_flush;
        logic [1:0]  e_cnt;
        logic [15:0] e_rb;
    } vec_t;

    vec_t vecs [23];
    vec_t exp_q [$];

    pipeline_hazard_ctrl #(.PRED_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_set(dec_set), .dec_dep(dec_dep),
        .stall(stall), .stall_any(stall_any), .fet_valid(fet_valid), .fet_is_br(fet_is_br),
        .fet_off(fet_off), .pc_in(pc_in), .psw_in(psw_in), .pc_next(pc_next),
        .fetch_hold(fetch_hold), .ex_resolve(ex_resolve), .ex_mispred(ex_mispred),
        .flush(flush), .rb_pc(rb_pc), .rb_psw(rb_psw), .rb_count(rb_count)
    );

    pipeline_hazard_ctrl #(.PRED_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_set(dec_set), .dec_dep(dec_dep),
        .stall(b_stall), .stall_any(b_stall_any), .fet_valid(fet_valid), .fet_is_br(fet_is_br),
        .fet_off(fet_off), .pc_in(pc_in), .psw_in(psw_in), .pc_next(b_pc_next),
        .fetch_hold(b_fetch_hold), .ex_resolve(ex_resolve), .ex_mispred(ex_mispred),
        .flush(b_flush), .rb_pc(b_rb_pc), .rb_psw(b_rb_psw), .rb_count(b_rb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input logic dv, input logic [7:0] set, input logic [7:0] dep,
                               input logic fv, input logic fb, input logic [12:0] off,
                               input logic [15:0] pc, input logic [15:0] psw,
                               input logic res, input logic mis,
                               input logic [7:0] es, input logic eh, input logic [15:0] epc,
                               input logic efl, input logic [1:0] ecnt, input logic [15:0] erb);
        vec_t r;
        r.dv = dv; r.set = set; r.dep = dep; r.fv = fv; r.fb = fb; r.off = off;
        r.pc = pc; r.psw = psw; r.res = res; r.mis = mis;
        r.e_stall = es; r.e_hold = eh; r.e_pc = epc; r.e_flush = efl; r.e_cnt = ecnt; r.e_rb = erb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        dec_valid  = x.dv;
        dec_set    = x.set;
        dec_dep    = x.dep;
        fet_valid  = x.fv;
        fet_is_br  = x.fb;
        fet_off    = x.off;
        pc_in      = x.pc;
        psw_in     = x.psw;
        ex_resolve = x.res;
        ex_mispred = x.mis;
    endtask

    task automatic step(input int idx);
        vec_t got;
        @(negedge clk);
        drive(vecs[idx]);
        #1;
        chk($sformatf("v%0d stall", idx), stall, vecs[idx].e_stall);
        chk($sformatf("v%0d stall_any", idx), stall_any, |vecs[idx].e_stall);
        chk($sformatf("v%0d fetch_hold", idx), fetch_hold, vecs[idx].e_hold);
        exp_q.push_back(vecs[idx]);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk($sformatf("v%0d pc_next", idx), pc_next, got.e_pc);
        chk($sformatf("v%0d flush", idx), flush, got.e_flush);
        chk($sformatf("v%0d rb_count", idx), rb_count, got.e_cnt);
        if (got.e_cnt != 2'd0) begin
            chk($sformatf("v%0d rb_pc", idx), rb_pc, got.e_rb);
        end
    endtask

    initial begin
        //          dv  set    dep    fv  fb  off       pc        psw       res mis | stall hold pc_next  fl cnt  rb_pc
        vecs[0]  = v(1, 8'h04, 8'h00, 0, 0, 13'h0000, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[1]  = v(1, 8'h00, 8'h04, 0, 0, 13'h0000, 16'h0000, 16'h0000, 0, 0, 8'h04, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[2]  = v(1, 8'h00, 8'h04, 0, 0, 13'h0000, 16'h0000, 16'h0000, 0, 0, 8'h04, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[3]  = v(1, 8'h00, 8'h04, 0, 0, 13'h0000, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[4]  = v(1, 8'h08, 8'h08, 0, 0, 13'h0000, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[5]  = v(0, 8'h00, 8'h08, 0, 0, 13'h0000, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[6]  = v(1, 8'h00, 8'h08, 0, 0, 13'h0000, 16'h0000, 16'h0000, 0, 0, 8'h08, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[7]  = v(1, 8'h00, 8'h08, 0, 0, 13'h0000, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[8]  = v(0, 8'h00, 8'h00, 1, 0, 13'h0000, 16'h0040, 16'h0000, 0, 0, 8'h00, 0, 16'h0042, 0, 0, 16'h0000);
        vecs[9]  = v(0, 8'h00, 8'h00, 1, 1, 13'h1FFE, 16'h0002, 16'hAAAA, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 16'h0004);
        vecs[10] = v(0, 8'h00, 8'h00, 0, 0, 13'h0000, 16'h0000, 16'h0000, 1, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[11] = v(1, 8'h10, 8'h00, 1, 1, 13'h0003, 16'h0100, 16'h1234, 0, 0, 8'h00, 0, 16'h0108, 0, 1, 16'h0102);
        vecs[12] = v(1, 8'h20, 8'h00, 1, 1, 13'h0003, 16'h0400, 16'h0000, 1, 1, 8'h00, 0, 16'h0102, 1, 0, 16'h0000);
        vecs[13] = v(1, 8'h40, 8'h30, 1, 1, 13'h0003, 16'h0200, 16'h0000, 0, 0, 8'h00, 0, 16'h0102, 0, 0, 16'h0000);
        vecs[14] = v(1, 8'h00, 8'h40, 0, 0, 13'h0000, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 16'h0102, 0, 0, 16'h0000);
        vecs[15] = v(0, 8'h00, 8'h00, 1, 1, 13'h0001, 16'h1000, 16'h0000, 0, 0, 8'h00, 0, 16'h1004, 0, 1, 16'h1002);
        vecs[16] = v(0, 8'h00, 8'h00, 1, 1, 13'h0001, 16'h1004, 16'h0000, 0, 0, 8'h00, 0, 16'h1008, 0, 2, 16'h1002);
        vecs[17] = v(0, 8'h00, 8'h00, 1, 1, 13'h0001, 16'h1008, 16'h0000, 0, 0, 8'h00, 1, 16'h1008, 0, 2, 16'h1002);
        vecs[18] = v(1, 8'h01, 8'h00, 1, 1, 13'h0001, 16'h1008, 16'h0000, 1, 0, 8'h00, 0, 16'h100C, 0, 2, 16'h1006);
        vecs[19] = v(1, 8'h02, 8'h00, 0, 0, 13'h0000, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[20] = v(1, 8'h00, 8'h02, 1, 1, 13'h0005, 16'h0300, 16'h0000, 0, 0, 8'h02, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[21] = v(1, 8'h00, 8'h02, 1, 1, 13'h0005, 16'h0300, 16'h0000, 0, 0, 8'h02, 0, 16'h0000, 0, 0, 16'h0000);
        vecs[22] = v(1, 8'h00, 8'h02, 1, 1, 13'h0005, 16'h0300, 16'h0000, 0, 0, 8'h00, 0, 16'h030C, 0, 1, 16'h0302);

        // power-on reset with a reading decode slot present
        rst_n = 1'b0;
        drive(v(1, 8'h00, 8'hFF, 0, 0, 13'h0, 16'h0, 16'h0, 0, 0, 8'h00, 0, 16'h0, 0, 0, 16'h0));
        #2;
        chk("reset pc_next", pc_next, 16'h0000);
        chk("reset flush", flush, 1'b0);
        chk("reset rb_count", rb_count, 2'd0);
        chk("reset rb_pc", rb_pc, 16'h0000);
        chk("reset rb_psw", rb_psw, 16'h0000);
        chk("reset stall", stall, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i <= 18; i++) begin
            step(i);
        end

        // asynchronous reset between edges with scoreboard and queue occupied
        #2;
        drive(v(1, 8'h00, 8'hFF, 0, 0, 13'h0, 16'h0, 16'h0, 0, 0, 8'h00, 0, 16'h0, 0, 0, 16'h0));
        #1;
        chk("pre-areset stall", stall, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("areset pc_next", pc_next, 16'h0000);
        chk("areset stall", stall, 8'h00);
        chk("areset rb_count", rb_count, 2'd0);
        chk("areset flush", flush, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 19; i <= 22; i++) begin
            step(i);
        end

        // both predictor modes on a backward wrap, then BTFN forward not-taken
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        drive(v(0, 8'h00, 8'h00, 1, 1, 13'h1FFE, 16'h0002, 16'h5555, 0, 0, 8'h00, 0, 16'h0, 0, 0, 16'h0));
        @(posedge clk);
        #1;
        chk("wrap mode0 pc_next", pc_next, 16'h0000);
        chk("wrap btfn pc_next", b_pc_next, 16'h0000);
        chk("wrap btfn rb_count", b_rb_count, 2'd1);
        chk("wrap btfn rb_pc", b_rb_pc, 16'h0004);
        chk("wrap btfn rb_psw", b_rb_psw, 16'h5555);
        chk("wrap mode0 rb_psw", rb_psw, 16'h5555);
        @(negedge clk);
        drive(v(0, 8'h00, 8'h00, 1, 1, 13'h0004, 16'h0002, 16'h6666, 1, 0, 8'h00, 0, 16'h0, 0, 0, 16'h0));
        #1;
        chk("btfn fetch_hold", b_fetch_hold, 1'b0);
        chk("btfn stall", b_stall, 8'h00);
        chk("btfn stall_any", b_stall_any, 1'b0);
        @(posedge clk);
        #1;
        chk("fwd btfn pc_next", b_pc_next, 16'h0004);
        chk("fwd btfn rb_pc", b_rb_pc, 16'h000C);
        chk("fwd btfn rb_psw", b_rb_psw, 16'h6666);
        chk("fwd btfn rb_count", b_rb_count, 2'd1);
        chk("fwd btfn flush", b_flush, 1'b0);
        chk("fwd mode0 pc_next", pc_next, 16'h000C);
        chk("fwd mode0 rb_pc", rb_pc, 16'h0004);
        @(negedge clk);
        drive(v(0, 8'h00, 8'h00, 0, 0, 13'h0, 16'h0, 16'h0, 0, 0, 8'h00, 0, 16'h0, 0, 0, 16'h0));
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
